ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be even and >= 8.
REQ-002 Parameter FAST_MULT, default 0; 0 = iterative multiply, 1 = single-cycle multiply. Divide is always iterative.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 Valid  in  1  an instruction is presented this cycle.
REQ-006 Func  in  6  MIPS funct code: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
REQ-007 A  in  WIDTH  rs operand; dividend or multiplicand; MTHI/MTLO source.
REQ-008 B  in  WIDTH  rt operand; divisor or multiplier.
REQ-009 Flush  in  1  pipeline flush; aborts any in-flight operation.
REQ-010 Stall  out  1  pipeline must hold this instruction.
REQ-011 Busy  out  1  iterative operation in flight.
REQ-012 Done  out  1  one-cycle pulse when HI/LO receive a result.
REQ-013 Out  out  WIDTH  MFHI/MFLO result.
REQ-014 HI, LO  out  WIDTH each  architectural registers.

Function
REQ-015 Accept: MULT/MULTU/DIV/DIVU SHALL be accepted when Valid=1, Busy=0 and Flush=0. Operands and op SHALL be captured at that edge.
REQ-016 States: IDLE and RUN only. Accept moves IDLE->RUN and loads the counter with WIDTH. RUN decrements the counter each cycle. RUN->IDLE on the edge where the counter equals 1, or on Flush.
REQ-017 Latency: HI/LO SHALL update, Busy SHALL fall and Done SHALL be 1 exactly WIDTH cycles after the accept edge.
REQ-018 Done SHALL be high for one cycle only and SHALL never assert without a completed operation.
REQ-019 FAST_MULT=1: MULT/MULTU SHALL write HI/LO on the accept edge itself. Busy SHALL stay 0 and Done SHALL pulse the following cycle.
REQ-020 Multiply result: {HI,LO} = full 2*WIDTH-bit product; signed for MULT, unsigned for MULTU.
REQ-021 Divide result: LO = quotient, HI = remainder, truncating toward zero; the remainder takes the dividend's sign (DIV).
REQ-022 Divide by zero: LO = all ones, HI = dividend. This SHALL complete with normal latency and no trap.
REQ-023 DIV of most-negative by -1: LO = most-negative, HI = 0.
REQ-024 MFHI/MFLO: when Valid=1 and Busy=0, Out SHALL combinationally equal HI or LO respectively. Otherwise Out = 0.
REQ-025 MTHI/MTLO: when Valid=1, Busy=0 and Flush=0, A SHALL be written to HI or LO on the edge.
REQ-026 Stall SHALL be 1 when Valid=1, Busy=1, Flush=0 and Func is any of the eight codes. Stall SHALL be 0 otherwise.
REQ-027 Done cycle: a request presented in the Done cycle SHALL see the new HI/LO and SHALL be serviced that cycle, with Stall=0.
REQ-028 Flush while Busy: RUN->IDLE at the next edge. HI/LO SHALL keep their pre-operation values and Done SHALL NOT pulse.
REQ-029 Flush with Valid in the same cycle: the instruction SHALL be discarded.
REQ-030 Any other Func, or Valid=0: no state change, Stall=0, Out=0.

Reset
REQ-031 nrst=0 SHALL immediately force HI=0, LO=0, Busy=0, Done=0, Out=0, Stall=0, state IDLE and counter 0, without waiting for clk.
REQ-032 Reset during RUN SHALL abandon the operation, and no Done SHALL follow release.
REQ-033 The first accept SHALL be possible on the first rising edge after nrst rises.

Verification
REQ-034 WIDTH=32, MULT A=-3, B=7 -> after 32 cycles Done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
REQ-035 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=0x00000007. DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
REQ-036 MFLO issued 3 cycles after a MULT accept -> Stall=1 until Done. In the Done cycle Out = new LO and Stall=0.
REQ-037 MTHI 0x1234, then MULT 2x3 with Flush asserted at cycle 10 -> Busy falls at the next edge, no Done, HI=0x1234.
REQ-038 nrst pulsed low mid-DIV, between clock edges -> all outputs 0 at once, and no Done after release.
REQ-039 FAST_MULT=1, WIDTH=16, MULTU 0xFFFF x 0xFFFF -> HI=0xFFFE, LO=0x0001 on the accept edge, Busy never 1.

Source files
------------

// File: rtl/ex_muldiv.sv
// Multiply/divide unit for a MIPS-style pipeline. It holds the HI/LO
// registers and runs MULT/MULTU/DIV/DIVU. Divide always takes WIDTH cycles,
// one quotient bit per cycle. Multiply also takes WIDTH cycles, one
// shift-add step per cycle, unless FAST_MULT selects a single-cycle multiply.
// Both iterative operations work on operand magnitudes, and the signs are
// applied when the result is written back. WIDTH must be even and >= 8.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no operation in flight; HI/LO moves and accepts are serviced
// S_RUN  | iterative multiply/divide in flight; down-counter tracks steps

module ex_muldiv #(
   parameter int WIDTH     = 32,
   parameter int FAST_MULT = 0
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             Valid,
   input  logic [5:0]       Func,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   output logic             Stall,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Out,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW   = $clog2(WIDTH + 1);
   localparam bit FAST = (FAST_MULT != 0);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic             op_mul_q;
   logic             neg_q;
   logic             rneg_q;
   logic             dz_q;
   logic [WIDTH-1:0] asave_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
   logic             done_q;

   logic             is_mul, is_div, is_md, is_known, is_signed;
   logic             issue, accept, fast_acc, start_run, tc, complete;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shl, div_diff;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [2*WIDTH-1:0] prod_w;
   logic [WIDTH-1:0]   fin_hi, fin_lo;

   // Instruction decode and the accept/issue qualifiers
   always_comb begin
      is_mul    = (Func == F_MULT) || (Func == F_MULTU);
      is_div    = (Func == F_DIV)  || (Func == F_DIVU);
      is_md     = is_mul || is_div;
      is_known  = is_md || (Func == F_MFHI) || (Func == F_MTHI) ||
                  (Func == F_MFLO) || (Func == F_MTLO);
      is_signed = (Func == F_MULT) || (Func == F_DIV);
      issue     = Valid && !Busy && !Flush;
      accept    = issue && is_md;
      fast_acc  = accept && is_mul && FAST;
      start_run = accept && !(is_mul && FAST);
      tc        = (cnt_q == CNT_ONE);
      complete  = (state_q == S_RUN) && tc && !Flush;
   end

   // Operand magnitudes for the iterative path, sign-extended operands for the fast one
   always_comb begin
      a_neg     = is_signed && A[WIDTH-1];
      b_neg     = is_signed && B[WIDTH-1];
      mag_a     = a_neg ? -A : A;
      mag_b     = b_neg ? -B : B;
      ext_a     = {{WIDTH{a_neg}}, A};
      ext_b     = {{WIDTH{b_neg}}, B};
      fast_prod = ext_a * ext_b;
   end

   // One iteration step: shift-add multiply or restoring divide
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shl  = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff = div_shl - {1'b0, opnd_q};
      if (op_mul_q) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         step_hi = div_diff[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
         step_hi = div_shl[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Sign fix-up applied to the last step's result; divide by zero bypasses it
   always_comb begin
      prod_w = {step_hi, step_lo};
      if (neg_q) prod_w = -prod_w;
      if (op_mul_q) begin
         fin_hi = prod_w[2*WIDTH-1:WIDTH];
         fin_lo = prod_w[WIDTH-1:0];
      end else if (dz_q) begin
         fin_hi = asave_q;
         fin_lo = '1;
      end else begin
         fin_hi = rneg_q ? -step_hi : step_hi;
         fin_lo = neg_q  ? -step_lo : step_lo;
      end
   end

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state: leave RUN on terminal count or flush
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_run) state_d = S_RUN;
         S_RUN:   if (Flush || tc) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture, step counter and iteration accumulators
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q    <= '0;
         op_mul_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         asave_q  <= '0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
      end else if (start_run) begin
         cnt_q    <= CNT_LOAD;
         op_mul_q <= is_mul;
         neg_q    <= a_neg ^ b_neg;
         rneg_q   <= a_neg;
         dz_q     <= (B == '0);
         asave_q  <= A;
         acc_hi_q <= '0;
         if (is_mul) begin
            opnd_q   <= mag_a;
            acc_lo_q <= mag_b;
         end else begin
            opnd_q   <= mag_b;
            acc_lo_q <= mag_a;
         end
      end else if (state_q == S_RUN) begin
         if (Flush) begin
            cnt_q <= '0;
         end else begin
            cnt_q    <= cnt_q - CNT_ONE;
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
         end
      end
   end

   // HI/LO architectural registers and the completion pulse
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         HI     <= '0;
         LO     <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= complete || fast_acc;
         if (complete) begin
            HI <= fin_hi;
            LO <= fin_lo;
         end else if (fast_acc) begin
            HI <= fast_prod[2*WIDTH-1:WIDTH];
            LO <= fast_prod[WIDTH-1:0];
         end else if (issue && (Func == F_MTHI)) begin
            HI <= A;
         end else if (issue && (Func == F_MTLO)) begin
            LO <= A;
         end
      end
   end

   // Status outputs and the MFHI/MFLO read port
   always_comb begin
      Busy  = (state_q == S_RUN);
      Done  = done_q;
      Stall = Valid && Busy && !Flush && is_known;
      Out   = '0;
      if (Valid && !Busy) begin
         if (Func == F_MFHI)      Out = HI;
         else if (Func == F_MFLO) Out = LO;
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a 32-bit iterative instance and a 16-bit
// fast-multiply instance sharing clock and reset.

module tb_ex_muldiv;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic        m_valid, m_flush, m_stall, m_busy, m_done;
   logic [5:0]  m_func;
   logic [31:0] m_a, m_b, m_out, m_hi, m_lo;

   logic        f_valid, f_flush, f_stall, f_busy, f_done;
   logic [5:0]  f_func;
   logic [15:0] f_a, f_b, f_out, f_hi, f_lo;

   int total = 0;
   int bad   = 0;

   ex_muldiv #(.WIDTH(32), .FAST_MULT(0)) u_dut_m (
      .clk(clk), .nrst(nrst), .Valid(m_valid), .Func(m_func), .A(m_a), .B(m_b),
      .Flush(m_flush), .Stall(m_stall), .Busy(m_busy), .Done(m_done),
      .Out(m_out), .HI(m_hi), .LO(m_lo));

   ex_muldiv #(.WIDTH(16), .FAST_MULT(1)) u_dut_f (
      .clk(clk), .nrst(nrst), .Valid(f_valid), .Func(f_func), .A(f_a), .B(f_b),
      .Flush(f_flush), .Stall(f_stall), .Busy(f_busy), .Done(f_done),
      .Out(f_out), .HI(f_hi), .LO(f_lo));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one iterative op on the 32-bit instance and check its result
   task automatic op_m(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int k;
      m_valid = 1'b1; m_func = fn; m_a = a; m_b = b;
      tick();
      m_valid = 1'b0; m_func = 6'h00;
      chk({tag, "_busy"}, 64'(m_busy), 64'(1));
      k = 0;
      while (!m_done && k < 60) begin
         tick();
         k++;
      end
      chk({tag, "_lat"}, 64'(k), 64'(32));
      chk({tag, "_hi"}, 64'(m_hi), 64'(eh));
      chk({tag, "_lo"}, 64'(m_lo), 64'(el));
      chk({tag, "_idle"}, 64'(m_busy), 64'(0));
      tick();
      chk({tag, "_pulse"}, 64'(m_done), 64'(0));
   endtask

   initial begin
      int k;
      int nost;
      int dcnt;
      m_valid = 1'b0; m_flush = 1'b0; m_func = 6'h00; m_a = '0; m_b = '0;
      f_valid = 1'b0; f_flush = 1'b0; f_func = 6'h00; f_a = '0; f_b = '0;

      #2;
      chk("rst_hi",   64'(m_hi),   64'(0));
      chk("rst_lo",   64'(m_lo),   64'(0));
      chk("rst_busy", 64'(m_busy), 64'(0));
      chk("rst_done", 64'(m_done), 64'(0));
      #10 nrst = 1'b1;

      // first op lands on the first edge after release
      op_m("mult",   F_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
      op_m("multu",  F_MULTU, 32'hFFFF_FFFD, 32'd7,        32'h0000_0006, 32'hFFFF_FFEB);
      op_m("div",    F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      op_m("divu0",  F_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
      op_m("divmin", F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      op_m("divu",   F_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E);
      op_m("divneg", F_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      op_m("mulmin", F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

      // read port decode
      m_valid = 1'b1; m_func = F_MFHI; #1;
      chk("mfhi_out", 64'(m_out), 64'(32'h4000_0000));
      m_func = 6'h15; #1;
      chk("badfn_out",   64'(m_out),   64'(0));
      chk("badfn_stall", 64'(m_stall), 64'(0));
      m_valid = 1'b0; m_func = F_MFLO; #1;
      chk("novalid_out", 64'(m_out), 64'(0));

      // MFLO behind an in-flight MULT
      tick();
      m_valid = 1'b1; m_func = F_MULT; m_a = 32'd5; m_b = 32'd6;
      tick();
      m_valid = 1'b0; m_func = 6'h00;
      tick(); tick(); tick();
      m_valid = 1'b1; m_func = F_MFLO; #1;
      chk("mflo_stall", 64'(m_stall), 64'(1));
      k = 3; nost = 0;
      while (!m_done && k < 60) begin
         tick();
         k++;
         if (!m_done && !m_stall) nost++;
      end
      chk("mflo_hold",    64'(nost),    64'(0));
      chk("mflo_lat",     64'(k),       64'(32));
      chk("mflo_out",     64'(m_out),   64'(30));
      chk("mflo_nostall", 64'(m_stall), 64'(0));
      m_valid = 1'b0; m_func = 6'h00;

      // flushed instructions are discarded
      tick();
      m_valid = 1'b1; m_func = F_MTLO; m_a = 32'h0000_DEAD; m_flush = 1'b1;
      tick();
      chk("flush_mt", 64'(m_lo), 64'(30));
      m_func = F_MULT; m_a = 32'd2; m_b = 32'd3;
      tick();
      chk("flush_acc", 64'(m_busy), 64'(0));
      m_valid = 1'b0; m_flush = 1'b0; m_func = 6'h00;

      // flush while busy keeps the old HI/LO and suppresses Done
      m_valid = 1'b1; m_func = F_MTHI; m_a = 32'h0000_1234;
      tick();
      chk("mthi", 64'(m_hi), 64'(32'h1234));
      m_func = F_MULT; m_a = 32'd2; m_b = 32'd3;
      tick();
      m_valid = 1'b0; m_func = 6'h00;
      repeat (10) tick();
      chk("fl_busy", 64'(m_busy), 64'(1));
      m_flush = 1'b1;
      tick();
      m_flush = 1'b0;
      chk("fl_drop", 64'(m_busy), 64'(0));
      dcnt = 0;
      repeat (40) begin
         if (m_done) dcnt++;
         tick();
      end
      chk("fl_nodone", 64'(dcnt), 64'(0));
      chk("fl_hi", 64'(m_hi), 64'(32'h1234));
      chk("fl_lo", 64'(m_lo), 64'(30));

      // asynchronous reset in the middle of a divide
      m_valid = 1'b1; m_func = F_DIV; m_a = 32'd100; m_b = 32'd7;
      tick();
      m_func = F_MFLO;
      repeat (5) tick();
      chk("ar_stall_pre", 64'(m_stall), 64'(1));
      #3 nrst = 1'b0;
      #1;
      chk("ar_busy",  64'(m_busy),  64'(0));
      chk("ar_hi",    64'(m_hi),    64'(0));
      chk("ar_lo",    64'(m_lo),    64'(0));
      chk("ar_done",  64'(m_done),  64'(0));
      chk("ar_stall", 64'(m_stall), 64'(0));
      chk("ar_out",   64'(m_out),   64'(0));
      m_valid = 1'b0; m_func = 6'h00;
      #2 nrst = 1'b1;
      m_valid = 1'b1; m_func = F_MTLO; m_a = 32'h0000_ABCD;
      tick();
      chk("ar_first", 64'(m_lo), 64'(32'hABCD));
      m_valid = 1'b0; m_func = 6'h00;
      dcnt = 0;
      repeat (40) begin
         if (m_done) dcnt++;
         tick();
      end
      chk("ar_nodone", 64'(dcnt), 64'(0));

      // 16-bit single-cycle multiply instance
      f_valid = 1'b1; f_func = F_MULTU; f_a = 16'hFFFF; f_b = 16'hFFFF;
      tick();
      f_valid = 1'b0; f_func = 6'h00;
      chk("fm_hi",   64'(f_hi),   64'(16'hFFFE));
      chk("fm_lo",   64'(f_lo),   64'(16'h0001));
      chk("fm_busy", 64'(f_busy), 64'(0));
      chk("fm_done", 64'(f_done), 64'(1));
      tick();
      chk("fm_pulse", 64'(f_done), 64'(0));
      f_valid = 1'b1; f_func = F_MULT; f_a = 16'hFFFD; f_b = 16'd7;
      tick();
      f_valid = 1'b0; f_func = 6'h00;
      chk("fs_hi",   64'(f_hi),   64'(16'hFFFF));
      chk("fs_lo",   64'(f_lo),   64'(16'hFFEB));
      chk("fs_busy", 64'(f_busy), 64'(0));
      tick();

      // divide stays iterative on the fast instance
      f_valid = 1'b1; f_func = F_DIV; f_a = 16'hFF9C; f_b = 16'd7;
      tick();
      f_valid = 1'b0; f_func = 6'h00;
      chk("fd_busy", 64'(f_busy), 64'(1));
      k = 0;
      while (!f_done && k < 60) begin
         tick();
         k++;
      end
      chk("fd_lat", 64'(k),    64'(16));
      chk("fd_hi",  64'(f_hi), 64'(16'hFFFE));
      chk("fd_lo",  64'(f_lo), 64'(16'hFFF2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
